// File: rtl/tft_line_fetch_if.sv
// Framebuffer memory read port shared between the line fetch controller
// (master) and the memory arbiter (slave). mem_data is valid in the cycle
// that mem_ack is high.
interface tft_line_fetch_if #(
  parameter int DW = 16,
  parameter int AW = 20
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_data
  );
endinterface

// File: rtl/tft_line_fetch.sv
// Scan-line prefetch controller. One half of a ping-pong line buffer is
// filled from the framebuffer while the other half is scanned out one pixel
// per pixclk. A line that is not completely fetched by the time it must be
// displayed sets a sticky underrun flag, and the skipped line is still
// counted so the following lines keep their correct addresses.
module tft_line_fetch #(
  parameter int            HN    = 10,
  parameter int            W     = 480,
  parameter int            LINES = 272,
  parameter int            DW    = 16,
  parameter int            AW    = 20,
  parameter logic [AW-1:0] BASE  = '0
) (
  input  logic            n_reset,
  input  logic            pixclk,
  input  logic            en,
  input  logic            hblank,
  input  logic            vblank,
  input  logic [HN-1:0]   x,
  tft_line_fetch_if.master mem,
  output logic [DW-1:0]   pixel,
  output logic            underrun
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam int LW = $clog2(LINES + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [AW-1:0] lbase;
  logic [LW-1:0] fline;
  logic          disp_sel;
  logic          hblank_q;
  logic          vblank_q;

  logic [DW-1:0] line_buf [0:1][0:W-1];

  logic          vbl_rise;
  logic          line_start;
  logic [AW-1:0] adv_base;
  logic [LW-1:0] adv_line;
  logic          wr_en;
  logic          rd_sel;
  logic [IW-1:0] rd_idx;
  logic          rd_in_range;

  // Timing generator edges: start of frame and start of each active line.
  assign vbl_rise   = vblank & ~vblank_q;
  assign line_start = ~hblank & hblank_q & ~vblank;

  // The display side reads the half that will be selected after this edge,
  // so the x=0 sample taken in the swap cycle already sees the new line.
  assign rd_sel      = disp_sel ^ (en & line_start);
  assign rd_idx      = x[IW-1:0];
  assign rd_in_range = (x < HN'(W));

  // Accepted words land in the fetch half, except when the fetch is being
  // cut short by a frame restart or a line swap in this very cycle.
  assign wr_en = en & mem.mem_req & mem.mem_ack & ~vbl_rise & ~line_start;

  // Address/line count to continue from at a swap: an unfinished fetch is
  // accounted as if it had completed so later lines stay aligned.
  always_comb begin
    adv_base = lbase;
    adv_line = fline;
    if (state == FETCH) begin
      adv_base = lbase + AW'(W);
      adv_line = fline + LW'(1);
    end
  end

  // Register blanking inputs for edge detection.
  always_ff @(posedge pixclk or negedge n_reset) begin
    if (!n_reset) begin
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      hblank_q <= hblank;
      vblank_q <= vblank;
    end
  end

  // Fetch sequencer: frame restart, line swaps and word-by-word fetch.
  always_ff @(posedge pixclk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= IDLE;
      idx          <= '0;
      lbase        <= BASE;
      fline        <= '0;
      disp_sel     <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      underrun     <= 1'b0;
    end else if (!en) begin
      state       <= IDLE;
      idx         <= '0;
      mem.mem_req <= 1'b0;
      underrun    <= 1'b0;
    end else if (vbl_rise) begin
      state        <= FETCH;
      idx          <= '0;
      lbase        <= BASE;
      fline        <= '0;
      mem.mem_req  <= 1'b1;
      mem.mem_addr <= BASE;
    end else if (line_start) begin
      disp_sel <= ~disp_sel;
      if (state == FETCH) begin
        underrun <= 1'b1;
      end
      idx   <= '0;
      lbase <= adv_base;
      fline <= adv_line;
      if (state != IDLE && adv_line < LW'(LINES)) begin
        state        <= FETCH;
        mem.mem_req  <= 1'b1;
        mem.mem_addr <= adv_base;
      end else begin
        state       <= IDLE;
        mem.mem_req <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (mem.mem_ack) begin
            if (idx == IW'(W - 1)) begin
              state       <= DONE;
              mem.mem_req <= 1'b0;
              idx         <= '0;
              lbase       <= lbase + AW'(W);
              fline       <= fline + LW'(1);
            end else begin
              idx          <= idx + IW'(1);
              mem.mem_addr <= mem.mem_addr + AW'(1);
            end
          end
        end
        DONE: begin
          mem.mem_req <= 1'b0;
        end
        IDLE: begin
          mem.mem_req <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Line buffer write port (fetch half).
  always_ff @(posedge pixclk) begin
    if (wr_en) begin
      line_buf[~disp_sel][idx] <= mem.mem_data;
    end
  end

  // Pixel output: buffered pixel during active video, black otherwise.
  always_ff @(posedge pixclk or negedge n_reset) begin
    if (!n_reset) begin
      pixel <= '0;
    end else if (en && !hblank && !vblank && rd_in_range) begin
      pixel <= line_buf[rd_sel][rd_idx];
    end else begin
      pixel <= '0;
    end
  end

endmodule

// File: tb/tb_tft_line_fetch.sv
// Directed bench for tft_line_fetch with a small line (W=4) and two-line
// frame. Memory returns addr[15:0]^16'h5A00 so pixel values identify the
// framebuffer word they came from.
module tb_tft_line_fetch;
  localparam int            HN    = 10;
  localparam int            W     = 4;
  localparam int            LINES = 2;
  localparam int            DW    = 16;
  localparam int            AW    = 20;
  localparam logic [AW-1:0] BASE  = 20'h100;

  logic          pixclk  = 1'b0;
  logic          n_reset = 1'b0;
  logic          en      = 1'b1;
  logic          hblank  = 1'b1;
  logic          vblank  = 1'b0;
  logic [HN-1:0] x       = '0;
  logic          ack_on  = 1'b0;
  logic [DW-1:0] pixel;
  logic          underrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic          mon_on     = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [AW-1:0] exp_next   = '0;
  int            words      = 0;

  typedef struct {
    logic          vb;
    logic          hb;
    int            xv;
    logic          ack;
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] pix;
    logic          und;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A00;
  endfunction

  tft_line_fetch_if #(.DW(DW), .AW(AW)) mem_bus ();

  assign mem_bus.mem_ack  = mem_bus.mem_req & ack_on;
  assign mem_bus.mem_data = mem_bus.mem_ack ? model_data(mem_bus.mem_addr) : '0;

  tft_line_fetch #(
    .HN(HN), .W(W), .LINES(LINES), .DW(DW), .AW(AW), .BASE(BASE)
  ) dut (
    .n_reset (n_reset),
    .pixclk  (pixclk),
    .en      (en),
    .hblank  (hblank),
    .vblank  (vblank),
    .x       (x),
    .mem     (mem_bus),
    .pixel   (pixel),
    .underrun(underrun)
  );

  // Free-running pixel clock.
  always #5 pixclk = ~pixclk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic vb, input logic hb, input int xv, input logic ack,
                         input logic req, input int addr, input int pix, input logic und);
    vec_t v;
    v.vb = vb; v.hb = hb; v.xv = xv; v.ack = ack;
    v.req = req; v.addr = AW'(addr); v.pix = DW'(pix); v.und = und;
    vecs.push_back(v);
  endtask

  // Drive one cycle of timing inputs and wait until the result is visible.
  task automatic apply_stimulus(input logic vb, input logic hb, input int xv, input logic ack);
    vblank = vb;
    hblank = hb;
    x      = HN'(xv);
    ack_on = ack;
    @(negedge pixclk);
  endtask

  // Memory-side scoreboard: address order and stability under stall.
  always @(negedge pixclk) begin
    #2;
    if (mon_on) begin
      if (prev_stall && mem_bus.mem_req)
        check_output("stall addr hold", 32'(mem_bus.mem_addr), 32'(prev_addr));
      if (mem_bus.mem_req && mem_bus.mem_ack) begin
        check_output("accepted addr", 32'(mem_bus.mem_addr), 32'(exp_next));
        exp_next = exp_next + AW'(1);
        words++;
      end
      prev_stall = mem_bus.mem_req & ~mem_bus.mem_ack;
      prev_addr  = mem_bus.mem_addr;
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    // vb hb x ack | req addr pix und
    add_vec(0,1,0,1, 0,'h000,'h0000,0);
    add_vec(1,1,0,1, 1,'h100,'h0000,0);
    add_vec(1,1,0,1, 1,'h101,'h0000,0);
    add_vec(1,1,0,1, 1,'h102,'h0000,0);
    add_vec(1,1,0,1, 1,'h103,'h0000,0);
    add_vec(1,1,0,1, 0,'h000,'h0000,0);
    add_vec(1,1,0,1, 0,'h000,'h0000,0);
    add_vec(0,1,0,1, 0,'h000,'h0000,0);
    add_vec(0,0,0,1, 1,'h104,'h5B00,0);
    add_vec(0,0,1,1, 1,'h105,'h5B01,0);
    add_vec(0,0,2,1, 1,'h106,'h5B02,0);
    add_vec(0,0,3,1, 1,'h107,'h5B03,0);
    add_vec(0,1,4,1, 0,'h000,'h0000,0);
    add_vec(0,1,4,1, 0,'h000,'h0000,0);
    add_vec(0,0,0,1, 0,'h000,'h5B04,0);
    add_vec(0,0,1,1, 0,'h000,'h5B05,0);
    add_vec(0,0,2,1, 0,'h000,'h5B06,0);
    add_vec(0,0,3,1, 0,'h000,'h5B07,0);
    add_vec(0,1,0,1, 0,'h000,'h0000,0);
    add_vec(0,0,0,1, 0,'h000,'h5B00,0);
    add_vec(0,1,0,1, 0,'h000,'h0000,0);
    add_vec(1,1,0,0, 1,'h100,'h0000,0);
    add_vec(1,1,0,0, 1,'h100,'h0000,0);
    add_vec(0,1,0,0, 1,'h100,'h0000,0);
    add_vec(0,0,0,0, 1,'h104,'h5B04,1);
    add_vec(0,0,1,1, 1,'h105,'h5B05,1);
    add_vec(0,0,2,1, 1,'h106,'h5B06,1);
    add_vec(0,0,3,1, 1,'h107,'h5B07,1);
    add_vec(0,1,0,1, 0,'h000,'h0000,1);
    add_vec(1,1,0,1, 1,'h100,'h0000,1);
    add_vec(1,1,0,1, 1,'h101,'h0000,1);

    // Reset state
    @(negedge pixclk);
    @(negedge pixclk);
    check_output("reset mem_req",  32'(mem_bus.mem_req),  0);
    check_output("reset mem_addr", 32'(mem_bus.mem_addr), 0);
    check_output("reset pixel",    32'(pixel),            0);
    check_output("reset underrun", 32'(underrun),         0);
    n_reset = 1'b1;

    // Table: fetch, display, idle after last line, stalled line -> underrun
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].vb, vecs[i].hb, vecs[i].xv, vecs[i].ack);
      check_output($sformatf("row%0d mem_req", i), 32'(mem_bus.mem_req), 32'(vecs[i].req));
      if (vecs[i].req)
        check_output($sformatf("row%0d mem_addr", i), 32'(mem_bus.mem_addr), 32'(vecs[i].addr));
      check_output($sformatf("row%0d pixel", i), 32'(pixel), 32'(vecs[i].pix));
      check_output($sformatf("row%0d underrun", i), 32'(underrun), 32'(vecs[i].und));
    end

    // Disable mid-fetch during active video
    en = 1'b0;
    apply_stimulus(0, 0, 1, 1);
    check_output("en0 mem_req",  32'(mem_bus.mem_req), 0);
    check_output("en0 pixel",    32'(pixel),           0);
    check_output("en0 underrun", 32'(underrun),        0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 0, 1);
      check_output("en1 no req", 32'(mem_bus.mem_req), 0);
    end
    apply_stimulus(0, 0, 0, 1);
    check_output("en1 line_start no req", 32'(mem_bus.mem_req), 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("en1 vbl req",  32'(mem_bus.mem_req),  1);
    check_output("en1 vbl addr", 32'(mem_bus.mem_addr), 32'h100);

    // Underrun, then asynchronous reset mid-fetch
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("pre-reset underrun", 32'(underrun),         1);
    check_output("pre-reset addr",     32'(mem_bus.mem_addr), 32'h104);
    vblank = 1'b0;
    hblank = 1'b1;
    #3 n_reset = 1'b0;
    #1;
    check_output("async rst mem_req",  32'(mem_bus.mem_req),  0);
    check_output("async rst mem_addr", 32'(mem_bus.mem_addr), 0);
    check_output("async rst underrun", 32'(underrun),         0);
    check_output("async rst pixel",    32'(pixel),            0);
    @(negedge pixclk);
    @(negedge pixclk);
    n_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, 1, 0, 1);
      check_output("post-rst no req", 32'(mem_bus.mem_req), 0);
    end
    apply_stimulus(0, 0, 0, 1);
    check_output("post-rst line_start no req", 32'(mem_bus.mem_req), 0);
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("post-rst vbl req",  32'(mem_bus.mem_req),  1);
    check_output("post-rst vbl addr", 32'(mem_bus.mem_addr), 32'h100);

    // Random 50% stalls across a whole two-line frame
    exp_next   = BASE;
    words      = 0;
    prev_stall = 1'b0;
    mon_on     = 1'b1;
    for (int k = 0; k < 200 && mem_bus.mem_req; k++)
      apply_stimulus(1, 1, 0, 1'($urandom_range(0, 1)));
    check_output("rand line0 finished", 32'(mem_bus.mem_req), 0);
    check_output("rand line0 words", 32'(words), W);
    apply_stimulus(0, 1, 0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < W; k++) begin
      apply_stimulus(0, 0, k, 1'($urandom_range(0, 1)));
      check_output($sformatf("rand line0 pixel x%0d", k), 32'(pixel), 32'h5B00 + 32'(k));
    end
    for (int k = 0; k < 200 && mem_bus.mem_req; k++)
      apply_stimulus(0, 1, 0, 1'($urandom_range(0, 1)));
    check_output("rand line1 finished", 32'(mem_bus.mem_req), 0);
    check_output("rand total words", 32'(words), 2 * W);
    mon_on = 1'b0;
    apply_stimulus(0, 1, 0, 1);
    for (int k = 0; k < W; k++) begin
      apply_stimulus(0, 0, k, 1);
      check_output($sformatf("rand line1 pixel x%0d", k), 32'(pixel), 32'h5B04 + 32'(k));
      check_output("last line idle req", 32'(mem_bus.mem_req), 0);
    end
    apply_stimulus(0, 1, 0, 1);
    check_output("hblank pixel", 32'(pixel), 0);
    check_output("rand underrun", 32'(underrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
